zeroriscy_axi_ss_bridge: RTL and testbench
==========================================

// Module: zeroriscy_axi_ss_bridge
// PURPOSE
//  Single-outstanding AXI4-Lite slave to simple-peripheral (req/gnt/rvalid) bridge.
//  Sits between the zeroriscy_sim_top AXI master port and the memory-mapped sim peripherals (uart_sim, sd_sim).
//  Decodes addresses to one-hot selects, arbitrates read vs write, and returns B/R responses with backpressure.
// PARAMETERS
//  NUM_SLV      2              number of peripheral windows (sel width)
//  SLV_BASE     32'h9A10_0000  base address of window 0
//  SLV_SHIFT    8              log2 window size; window i = SLV_BASE + (i << SLV_SHIFT)
//  TIMEOUT_CYC  255            peripheral timeout in cycles (used only with SS_TIMEOUT_EN)
// PORTS
//  clk           in   1        clock, all logic on posedge
//  reset         in   1        asynchronous, active-high reset
//  s_awaddr      in   32       AXI write address
//  s_awvalid     in   1 / s_awready out 1   AW handshake
//  s_wdata       in   32 / s_wstrb in 4     write data / byte strobes
//  s_wvalid      in   1 / s_wready  out 1   W handshake
//  s_bresp       out  2 / s_bvalid out 1 / s_bready in 1   write response
//  s_araddr      in   32       AXI read address
//  s_arvalid     in   1 / s_arready out 1   AR handshake
//  s_rdata       out  32 / s_rresp out 2 / s_rlast out 1 (=1 whenever s_rvalid=1)
//  s_rvalid      out  1 / s_rready  in 1    read data handshake
//  ss_req        out  1        peripheral request, held until ss_gnt
//  ss_sel        out  NUM_SLV  one-hot window select, valid with ss_req
//  ss_we / ss_be out  1 / 4    write enable / byte enables (=wstrb for writes, 4'hF for reads)
//  ss_addr / ss_wdata out 32   byte address / write data, stable while ss_req=1
//  ss_gnt        in   1        peripheral accepted request
//  ss_rvalid / ss_err in 1     completion strobe / error, for reads AND writes
//  ss_rdata      in   32       read data, valid with ss_rvalid
// BEHAVIOUR
//  - Reset: FSM=IDLE; all ready/valid/req outputs 0, sel/be/we 0, addr/wdata/rdata 0, resp 2'b00; write has priority.
//  - FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on decode error.
//  - IDLE: arready/awready/wready are 1 only in the acceptance cycle (comb from valids + arbitration).
//    Write eligible only when s_awvalid & s_wvalid both 1; AW and W are accepted in the same cycle, never separately.
//    Both eligible: alternating priority; served type loses priority next time.
//  - Decode: hit when addr[31:SLV_SHIFT+clog2(NUM_SLV)] matches SLV_BASE and index < NUM_SLV.
//    Miss: no ss_req, go to RESP with resp=2'b11 (DECERR), rdata=0.
//  - REQ: ss_req=1 from cycle after acceptance (registered), held with stable fields until ss_gnt sampled 1; then WAIT.
//  - WAIT: capture ss_rdata (reads) and resp = ss_err ? 2'b10 : 2'b00 when ss_rvalid=1; go to RESP.
//    ss_rvalid in the same cycle as ss_gnt is legal: completion taken, skip WAIT straight to RESP.
//  - RESP: s_bvalid (write) or s_rvalid (read) =1, data/resp stable until matching ready; then IDLE.
//    New request accepted no earlier than the cycle after the response handshake.
//  - Min latency (gnt comb, rvalid next cycle): accept T, ss_req T+1, rvalid T+2, s_rvalid/bvalid T+3.
//  - ss_rvalid/ss_err outside WAIT (or the REQ gnt cycle) are ignored.
//  - Reset asserted mid-transaction aborts it immediately; no response is issued afterwards.
//  - s_wstrb==0 is forwarded as-is (ss_be=0), not filtered.
// CONFIGURATION
//  SS_TIMEOUT_EN defined: counter cleared on entering REQ, counts in REQ/WAIT.
//    At TIMEOUT_CYC cycles: drop ss_req, go to RESP with resp=2'b10, rdata=32'h0.
//    Late ss_rvalid is ignored.
//  SS_TIMEOUT_EN undefined: no counter; bridge waits forever in REQ/WAIT. TIMEOUT_CYC is unused.
// TESTING
//  1 Write 0x9A10_0004 data 0x41 strb 4'h1, gnt comb, rvalid+1
//    -> ss_sel=2'b01 ss_we=1 ss_be=1; bresp=00; bvalid 3 cycles after AW/W accept.
//  2 Read 0x9A10_0100, ss_rdata=0x1234_5678, ss_err=0
//    -> ss_sel=2'b10; rdata=0x1234_5678 rresp=00 rlast=1.
//  3 Read 0x8000_0000 -> no ss_req; rresp=2'b11 rdata=0 one cycle after AR accept.
//  4 AR and AW+W valid same cycle after reset, both to 0x9A10_0000 -> write served first, then read; next tie -> read first.
//  5 Hold s_rready=0 10 cycles with new AR pending -> rvalid/rdata stable, arready=0 until handshake.
//  6 ss_gnt withheld 300 cycles
//    -> SS_TIMEOUT_EN: rresp=10 after 255 cycles.
//    -> otherwise: no response.
//    -> reset pulse mid-wait: all outputs 0.

Source files
------------

// File: rtl/zeroriscy_axi_ss_bridge.sv
// Single-outstanding AXI4-Lite slave to req/gnt/rvalid peripheral bridge.
// Optional macro SS_TIMEOUT_EN aborts peripheral accesses that stall for TIMEOUT_CYC cycles.
module zeroriscy_axi_ss_bridge #(
  parameter int unsigned NUM_SLV     = 2,
  parameter logic [31:0] SLV_BASE    = 32'h9A10_0000,
  parameter int unsigned SLV_SHIFT   = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        s_awaddr,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [31:0]        s_wdata,
  input  logic [3:0]         s_wstrb,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [1:0]         s_bresp,
  output logic               s_bvalid,
  input  logic               s_bready,
  input  logic [31:0]        s_araddr,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [31:0]        s_rdata,
  output logic [1:0]         s_rresp,
  output logic               s_rlast,
  output logic               s_rvalid,
  input  logic               s_rready,
  output logic               ss_req,
  output logic [NUM_SLV-1:0] ss_sel,
  output logic               ss_we,
  output logic [3:0]         ss_be,
  output logic [31:0]        ss_addr,
  output logic [31:0]        ss_wdata,
  input  logic               ss_gnt,
  input  logic               ss_rvalid,
  input  logic               ss_err,
  input  logic [31:0]        ss_rdata,
  output logic [1:0]         dbg_state
);
  localparam int unsigned IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned TAG_LSB = SLV_SHIFT + IDX_W;
  localparam logic [IDX_W:0] NUM_SLV_W = NUM_SLV[IDX_W:0];

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e             state_q;
  logic               wr_prio_q, is_wr_q;
  logic               bvalid_q, rvalid_q, req_q, we_q;
  logic [1:0]         resp_q;
  logic [31:0]        rdata_q, addr_q, wdata_q;
  logic [3:0]         be_q;
  logic [NUM_SLV-1:0] sel_q;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid and its payload never drop or change before that edge.
  logic        wr_elig, rd_elig, pick_wr, acc_wr, acc_rd, acc_hit, tmo;
  logic [31:0] acc_addr;
  logic [IDX_W-1:0] acc_idx;
  assign wr_elig   = s_awvalid & s_wvalid;
  assign rd_elig   = s_arvalid;
  assign pick_wr   = wr_elig & (~rd_elig | wr_prio_q);
  assign acc_wr    = (state_q == IDLE) & pick_wr;
  assign acc_rd    = (state_q == IDLE) & rd_elig & ~pick_wr;
  assign s_awready = acc_wr;
  assign s_wready  = acc_wr;
  assign s_arready = acc_rd;
  assign acc_addr  = acc_wr ? s_awaddr : s_araddr;
  assign acc_idx   = acc_addr[SLV_SHIFT +: IDX_W];
  assign acc_hit   = (acc_addr[31:TAG_LSB] == SLV_BASE[31:TAG_LSB]) && ({1'b0, acc_idx} < NUM_SLV_W);

`ifdef SS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   cnt_q <= '0;
    else if (state_q == REQ || state_q == WAIT)  cnt_q <= cnt_q + 1'b1;
    else                                         cnt_q <= '0;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = |TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  // Completion is only honoured in WAIT or in the cycle the grant lands.
  logic        fin;
  logic [1:0]  fin_resp;
  logic [31:0] fin_rdata;
  always_comb begin
    fin       = 1'b0;
    fin_resp  = 2'b00;
    fin_rdata = '0;
    if (((state_q == REQ && ss_gnt) || state_q == WAIT) && ss_rvalid) begin
      fin       = 1'b1;
      fin_resp  = ss_err ? 2'b10 : 2'b00;
      fin_rdata = is_wr_q ? 32'h0 : ss_rdata;
    end else if ((state_q == REQ || state_q == WAIT) && tmo) begin
      fin      = 1'b1;
      fin_resp = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE; wr_prio_q <= 1'b1; is_wr_q <= 1'b0;
      bvalid_q <= 1'b0; rvalid_q <= 1'b0; req_q <= 1'b0; we_q <= 1'b0;
      resp_q <= 2'b00; rdata_q <= '0; addr_q <= '0; wdata_q <= '0;
      be_q <= '0; sel_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (acc_wr | acc_rd) begin
          if (wr_elig & rd_elig) wr_prio_q <= ~acc_wr;
          is_wr_q <= acc_wr;
          addr_q  <= acc_addr;
          wdata_q <= acc_wr ? s_wdata : 32'h0;
          be_q    <= acc_wr ? s_wstrb : 4'hF;
          we_q    <= acc_wr;
          sel_q   <= acc_hit ? (NUM_SLV'(1) << acc_idx) : '0;
          if (acc_hit) begin
            req_q   <= 1'b1;
            state_q <= REQ;
          end else begin
            resp_q   <= 2'b11;
            rdata_q  <= '0;
            bvalid_q <= acc_wr;
            rvalid_q <= acc_rd;
            state_q  <= RESP;
          end
        end
        REQ, WAIT: if (fin) begin
          req_q    <= 1'b0;
          resp_q   <= fin_resp;
          rdata_q  <= fin_rdata;
          bvalid_q <= is_wr_q;
          rvalid_q <= ~is_wr_q;
          state_q  <= RESP;
        end else if (state_q == REQ && ss_gnt) begin
          req_q   <= 1'b0;
          state_q <= WAIT;
        end
        RESP: if ((is_wr_q & s_bready) | (~is_wr_q & s_rready)) begin
          bvalid_q <= 1'b0;
          rvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_bvalid  = bvalid_q;
  assign s_bresp   = resp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = resp_q;
  assign s_rdata   = rdata_q;
  assign s_rlast   = rvalid_q;
  assign ss_req    = req_q;
  assign ss_sel    = sel_q;
  assign ss_we     = we_q;
  assign ss_be     = be_q;
  assign ss_addr   = addr_q;
  assign ss_wdata  = wdata_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_zeroriscy_axi_ss_bridge.sv
// Bench for zeroriscy_axi_ss_bridge: directed cases plus randomized transactions
// checked against an address-range/latency model and an expected-response queue.
module tb_zeroriscy_axi_ss_bridge;
  localparam logic [31:0] BASE  = 32'h9A10_0000;
  localparam int          SHIFT = 8;
  localparam int          NSLV  = 2;

  logic        clk, reset;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, ss_addr, ss_wdata, ss_rdata;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [3:0]  s_wstrb, ss_be;
  logic [1:0]  s_bresp, s_rresp, ss_sel, dbg_state;
  logic        ss_req, ss_we, ss_gnt, ss_rvalid, ss_err;

  zeroriscy_axi_ss_bridge dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ss_req(ss_req), .ss_sel(ss_sel), .ss_we(ss_we), .ss_be(ss_be),
    .ss_addr(ss_addr), .ss_wdata(ss_wdata), .ss_gnt(ss_gnt),
    .ss_rvalid(ss_rvalid), .ss_err(ss_err), .ss_rdata(ss_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int n_assert = 0;
  int n_fail = 0;
  logic [33:0] exp_q[$];
  bit m_wr_prio;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic void model_decode(input logic [31:0] a, output bit hit, output logic [1:0] sel);
    longint off;
    off = longint'(a) - longint'(BASE);
    hit = (off >= 0) && (off < (longint'(NSLV) << SHIFT));
    sel = hit ? 2'(1 << (off >> SHIFT)) : 2'b00;
  endfunction

  task automatic push_expect(input bit is_wr, input logic [31:0] addr, input bit err, input logic [31:0] prd);
    bit hit; logic [1:0] sel; logic [1:0] r;
    model_decode(addr, hit, sel);
    r = !hit ? 2'b11 : (err ? 2'b10 : 2'b00);
    exp_q.push_back({r, (hit && !is_wr) ? prd : 32'h0});
  endtask

  // driver tasks
  task automatic start_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    s_awaddr = a; s_wdata = d; s_wstrb = strb; s_awvalid = 1'b1; s_wvalid = 1'b1;
  endtask

  task automatic start_rd(input logic [31:0] a);
    s_araddr = a; s_arvalid = 1'b1;
  endtask

  task automatic wait_accept(input bit is_wr, output int acc);
    int n;
    n = 0;
    #1;
    while (!(is_wr ? s_awready : s_arready) && n < 100) begin step(); n++; end
    if (is_wr) begin
      check("aw_accept", s_awready, 1);
      check("w_with_aw", s_wready, 1);
      check("ar_not_with_wr", s_arready, 0);
    end else begin
      check("ar_accept", s_arready, 1);
      check("aw_not_with_rd", s_awready, 0);
    end
    acc = cyc;
    step();
    if (is_wr) begin s_awvalid = 1'b0; s_wvalid = 1'b0; end
    else s_arvalid = 1'b0;
    #1;
  endtask

  task automatic serve(input bit is_wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                       input int gnt_dly, input int rv_dly, input bit err, input logic [31:0] prd);
    bit hit; logic [1:0] sel;
    model_decode(addr, hit, sel);
    if (!hit) begin
      check("miss_no_req", ss_req, 0);
      return;
    end
    check("req", ss_req, 1);
    check("sel", ss_sel, sel);
    check("we", ss_we, is_wr);
    check("be", ss_be, is_wr ? strb : 4'hF);
    check("addr", ss_addr, addr);
    if (is_wr) check("wdata", ss_wdata, wd);
    for (int i = 0; i < gnt_dly; i++) begin
      ss_rvalid = 1'($urandom_range(0, 1)); ss_err = 1'b1; ss_rdata = $urandom;
      step();
      check("req_held", ss_req, 1);
      check("addr_held", ss_addr, addr);
      check("sel_held", ss_sel, sel);
    end
    ss_gnt = 1'b1; ss_rvalid = (rv_dly == 0); ss_err = err & (rv_dly == 0); ss_rdata = prd;
    step();
    ss_gnt = 1'b0; ss_rvalid = 1'b0; ss_err = 1'b0;
    check("req_drop", ss_req, 0);
    if (rv_dly > 0) begin
      for (int i = 1; i < rv_dly; i++) begin ss_rdata = $urandom; step(); end
      ss_rvalid = 1'b1; ss_err = err; ss_rdata = prd;
      step();
      ss_rvalid = 1'b0; ss_err = 1'b0;
    end
  endtask

  task automatic finish(input bit is_wr, input int acc, input int exp_lat, input int rsp_dly, input bit hold_ar);
    logic [33:0] e;
    int n;
    n = 0;
    while (!(is_wr ? s_bvalid : s_rvalid) && n < 400) begin step(); n++; end
    check("resp_valid", is_wr ? s_bvalid : s_rvalid, 1);
    check("other_valid_low", is_wr ? s_rvalid : s_bvalid, 0);
    if (exp_lat >= 0) check("latency", cyc - acc, exp_lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h0;
    for (int i = 0; i <= rsp_dly; i++) begin
      if (is_wr) check("bresp", s_bresp, e[33:32]);
      else begin
        check("rresp", s_rresp, e[33:32]);
        check("rdata", s_rdata, e[31:0]);
        check("rlast", s_rlast, 1);
      end
      if (i < rsp_dly) begin
        if (hold_ar) begin s_araddr = BASE + 32'h8; s_arvalid = 1'b1; #1; check("arready_held_off", s_arready, 0); end
        step();
        check("valid_held", is_wr ? s_bvalid : s_rvalid, 1);
      end
    end
    if (is_wr) s_bready = 1'b1; else s_rready = 1'b1;
    step();
    s_bready = 1'b0; s_rready = 1'b0;
    if (hold_ar) s_arvalid = 1'b0;
    check("valid_cleared", is_wr ? s_bvalid : s_rvalid, 0);
  endtask

  task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input int gnt_dly, input int rv_dly, input bit err, input logic [31:0] prd,
                        input int rsp_dly, input bit hold_ar);
    int acc; bit hit; logic [1:0] sel;
    model_decode(addr, hit, sel);
    if (is_wr) start_wr(addr, data, strb); else start_rd(addr);
    push_expect(is_wr, addr, err, prd);
    wait_accept(is_wr, acc);
    serve(is_wr, addr, data, strb, gnt_dly, rv_dly, err, prd);
    finish(is_wr, acc, hit ? 2 + gnt_dly + rv_dly : 1, rsp_dly, hold_ar);
  endtask

  task automatic do_tie(input logic [31:0] aw, input logic [31:0] ar);
    bit first_wr; int acc; logic [31:0] prd, wd;
    prd = $urandom; wd = $urandom;
    first_wr = m_wr_prio;
    m_wr_prio = !m_wr_prio;
    start_wr(aw, wd, 4'hF);
    start_rd(ar);
    for (int k = 0; k < 2; k++) begin
      bit w;
      w = (k == 0) ? first_wr : !first_wr;
      push_expect(w, w ? aw : ar, 1'b0, prd);
      wait_accept(w, acc);
      serve(w, w ? aw : ar, wd, 4'hF, 0, 1, 1'b0, prd);
      finish(w, acc, 3, 0, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    #1;
    check(tag, {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_rlast, s_bresp, s_rresp, s_rdata,
                ss_req, ss_sel, ss_we, ss_be, ss_addr, ss_wdata, dbg_state}, 0);
  endtask

  initial begin
    int acc; bit seen, held;
    logic [31:0] a;
    reset = 1'b1; m_wr_prio = 1'b1;
    s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0; s_bready = 0;
    s_araddr = 0; s_arvalid = 0; s_rready = 0;
    ss_gnt = 0; ss_rvalid = 0; ss_err = 0; ss_rdata = 0;
    repeat (3) step();
    check_all_zero("reset_state");
    reset = 1'b0;
    step();

    do_txn(1'b1, BASE + 32'h4, 32'h41, 4'h1, 0, 1, 1'b0, 32'h0, 0, 1'b0);
    do_txn(1'b0, BASE + 32'h100, 32'h0, 4'h0, 0, 1, 1'b0, 32'h1234_5678, 0, 1'b0);
    do_txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    do_txn(1'b1, BASE + 32'h1FC, 32'hCAFE_F00D, 4'h0, 1, 2, 1'b1, 32'h0, 1, 1'b0);
    do_txn(1'b1, BASE + 32'h200, 32'h5, 4'h3, 0, 1, 1'b0, 32'h0, 0, 1'b0);
    do_txn(1'b0, BASE - 32'h4, 32'h0, 4'h0, 0, 1, 1'b0, 32'h7, 0, 1'b0);
    do_tie(BASE, BASE);
    do_tie(BASE, BASE);
    do_txn(1'b0, BASE + 32'h8, 32'h0, 4'h0, 0, 0, 1'b1, $urandom, 10, 1'b1);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + (32'($urandom_range(0, 1)) << SHIFT) + (32'($urandom_range(0, 63)) << 2);
        3:       a = BASE + 32'h200 + (32'($urandom_range(0, 63)) << 2);
        4:       a = $urandom;
        default: a = BASE - 32'h4;
      endcase
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 4), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
             $urandom, $urandom_range(0, 3), 1'b0);
    end

`ifdef SS_TIMEOUT_EN
    exp_q.push_back({2'b10, 32'h0});
    start_rd(BASE + 32'h100);
    wait_accept(1'b0, acc);
    finish(1'b0, acc, 256, 0, 1'b0);
    start_rd(BASE + 32'h100);
    wait_accept(1'b0, acc);
    repeat (20) step();
    check("stall_req_held", ss_req, 1);
`else
    start_rd(BASE + 32'h100);
    wait_accept(1'b0, acc);
    seen = 1'b0; held = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      seen = seen | s_rvalid | s_bvalid;
      held = held & ss_req;
    end
    check("stall_no_resp", seen, 0);
    check("stall_req_held", held, 1);
`endif
    reset = 1'b1;
    check_all_zero("reset_mid_wait");
    step();
    reset = 1'b0;
    m_wr_prio = 1'b1;
    ss_gnt = 1'b1; ss_rvalid = 1'b1; ss_rdata = $urandom;
    step();
    step();
    ss_gnt = 1'b0; ss_rvalid = 1'b0;
    check("no_resp_after_reset", {s_rvalid, s_bvalid, ss_req}, 0);

    do_tie(BASE + 32'h104, BASE + 32'h10);
    do_txn(1'b0, BASE + 32'h1F0, 32'h0, 4'h0, 2, 1, 1'b0, $urandom, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
